// File: rtl/mem_pkg.sv
// Shared types for the data-memory bridge: access sizes, FSM states and a lane-shift helper.
package mem_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10
    } mem_size_e;

    typedef logic [1:0] dmem_state_e;

    localparam dmem_state_e IDLE = 2'd0;
    localparam dmem_state_e REQ  = 2'd1;
    localparam dmem_state_e WAIT = 2'd2;
    localparam dmem_state_e DONE = 2'd3;

    // Bit shift amount for a byte offset within a 32-bit word.
    function automatic logic [4:0] lane_shamt(input logic [1:0] off);
        return {off, 3'b000};
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: byte enables, store-data shift, load-data right-align and
// alignment check for a 32-bit little-endian bus.
module dmem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        misaligned_o
);

    always_comb begin
        be_o         = 4'b0000;
        misaligned_o = 1'b1;
        case (size_i)
            MEM_BYTE: begin
                be_o         = 4'b0001 << off_i;
                misaligned_o = 1'b0;
            end
            MEM_HALF: begin
                be_o         = 4'b0011 << off_i;
                misaligned_o = off_i[0];
            end
            MEM_WORD: begin
                be_o         = 4'b1111;
                misaligned_o = (off_i != 2'b00);
            end
            default: ;
        endcase
    end

    // Upper store bytes fall off the top; they never wrap into low lanes.
    assign wdata_o = wdata_i << lane_shamt(off_i);
    assign rdata_o = rdata_i >> lane_shamt(off_i);

endmodule

// File: rtl/dmem_bridge.sv
// LSU to data-memory bus bridge: req/gnt/rvalid handshake with wait states, core stall,
// alignment fault and bus timeout reporting.
module dmem_bridge
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        rsp_valid,
    output logic        misaligned,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] TmoLast = CntW'(TIMEOUT_CYCLES == 0 ? 0 : TIMEOUT_CYCLES - 1);

    dmem_state_e     state_q, state_d;
    logic [1:0]      off_q, off_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            mem_req_q, mem_req_d;
    logic            mem_we_q, mem_we_d;
    logic [31:0]     mem_addr_q, mem_addr_d;
    logic [3:0]      mem_be_q, mem_be_d;
    logic [31:0]     mem_wdata_q, mem_wdata_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            misaligned_q, misaligned_d;
    logic            bus_err_q, bus_err_d;

    logic            access;
    logic            tmo_hit;
    logic [1:0]      off;
    logic [3:0]      be;
    logic [31:0]     wdata_sh;
    logic [31:0]     rdata_sh;
    logic            mis;

    assign access  = rd_en | wr_en;
    assign tmo_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TmoLast);
    // Request inputs are only trusted in IDLE; afterwards the captured offset is used.
    assign off     = (state_q == IDLE) ? addr[1:0] : off_q;

    dmem_lane_align u_lane_align (
        .off_i        (off),
        .size_i       (size),
        .wdata_i      (wdata),
        .rdata_i      (mem_rdata),
        .be_o         (be),
        .wdata_o      (wdata_sh),
        .rdata_o      (rdata_sh),
        .misaligned_o (mis)
    );

    always_comb begin
        state_d      = state_q;
        off_d        = off_q;
        cnt_d        = cnt_q;
        mem_req_d    = 1'b0;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_be_d     = mem_be_q;
        mem_wdata_d  = mem_wdata_q;
        rdata_d      = rdata_q;
        rsp_valid_d  = 1'b0;
        misaligned_d = 1'b0;
        bus_err_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (access) begin
                    off_d       = addr[1:0];
                    mem_we_d    = wr_en;
                    mem_addr_d  = {addr[31:2], 2'b00};
                    mem_be_d    = be;
                    mem_wdata_d = wdata_sh;
                    if (mis) begin
                        state_d      = DONE;
                        rsp_valid_d  = 1'b1;
                        misaligned_d = 1'b1;
                        rdata_d      = '0;
                    end else begin
                        state_d   = REQ;
                        mem_req_d = 1'b1;
                        cnt_d     = '0;
                    end
                end
            end
            REQ: begin
                cnt_d     = cnt_q + CntW'(1);
                mem_req_d = 1'b1;
                if (mem_gnt) begin
                    mem_req_d = 1'b0;
                    if (mem_we_q) begin
                        state_d     = DONE;
                        rsp_valid_d = 1'b1;
                    end else if (mem_rvalid) begin
                        state_d     = DONE;
                        rsp_valid_d = 1'b1;
                        rdata_d     = rdata_sh;
                    end else begin
                        state_d = WAIT;
                    end
                end else if (tmo_hit) begin
                    state_d     = DONE;
                    mem_req_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    bus_err_d   = 1'b1;
                    rdata_d     = '0;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + CntW'(1);
                if (mem_rvalid) begin
                    state_d     = DONE;
                    rsp_valid_d = 1'b1;
                    rdata_d     = rdata_sh;
                end else if (tmo_hit) begin
                    state_d     = DONE;
                    rsp_valid_d = 1'b1;
                    bus_err_d   = 1'b1;
                    rdata_d     = '0;
                end
            end
            DONE: begin
                // Core advances on this edge, so IDLE sees either nothing or a fresh request.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            off_q        <= '0;
            cnt_q        <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_be_q     <= '0;
            mem_wdata_q  <= '0;
            rdata_q      <= '0;
            rsp_valid_q  <= 1'b0;
            misaligned_q <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            off_q        <= off_d;
            cnt_q        <= cnt_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_be_q     <= mem_be_d;
            mem_wdata_q  <= mem_wdata_d;
            rdata_q      <= rdata_d;
            rsp_valid_q  <= rsp_valid_d;
            misaligned_q <= misaligned_d;
            bus_err_q    <= bus_err_d;
        end
    end

    assign stall      = ((state_q == IDLE) && access) || (state_q == REQ) || (state_q == WAIT);
    assign rdata      = rdata_q;
    assign rsp_valid  = rsp_valid_q;
    assign misaligned = misaligned_q;
    assign bus_err    = bus_err_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_be     = mem_be_q;
    assign mem_wdata  = mem_wdata_q;

endmodule
